// File: rtl/btb_read_if.sv
// btb_read_if: groups the lookup request, BTB file read, BTB write snoop and prediction
// signals of btb_read.
//   master: front end + BTB file side (drives requests, read data and write snoop)
//   slave : btb_read (drives rd_set, prediction outputs and statistics)
interface btb_read_if #(
    parameter int unsigned TAGW = 27
);
    // Fetch request / pipeline control
    logic            req_valid;
    logic [TAGW+2:0] req_pc;
    logic            stall;
    logic            flush;

    // BTB file synchronous read port
    logic [2:0]      rd_set;
    logic            rd_valid0;
    logic            rd_valid1;
    logic [TAGW-1:0] rd_tag0;
    logic [TAGW-1:0] rd_tag1;
    logic [31:0]     rd_target0;
    logic [31:0]     rd_target1;
    logic [1:0]      rd_state0;
    logic [1:0]      rd_state1;

    // Snoop of the BTB file write port
    logic            wr_en;
    logic [2:0]      wr_set;
    logic            wr_way;
    logic            wr_valid;
    logic [TAGW-1:0] wr_tag;
    logic [31:0]     wr_target;
    logic [1:0]      wr_state;

    // Registered prediction and statistics
    logic            pred_valid;
    logic [TAGW+2:0] pred_pc;
    logic            pred_hit;
    logic            pred_way;
    logic            pred_taken;
    logic [31:0]     pred_target;
    logic [1:0]      pred_state;
    logic [15:0]     lookup_cnt;
    logic [15:0]     hit_cnt;

    modport master (
        output req_valid, req_pc, stall, flush,
        output rd_valid0, rd_valid1, rd_tag0, rd_tag1,
        output rd_target0, rd_target1, rd_state0, rd_state1,
        output wr_en, wr_set, wr_way, wr_valid, wr_tag, wr_target, wr_state,
        input  rd_set,
        input  pred_valid, pred_pc, pred_hit, pred_way, pred_taken, pred_target, pred_state,
        input  lookup_cnt, hit_cnt
    );

    modport slave (
        input  req_valid, req_pc, stall, flush,
        input  rd_valid0, rd_valid1, rd_tag0, rd_tag1,
        input  rd_target0, rd_target1, rd_state0, rd_state1,
        input  wr_en, wr_set, wr_way, wr_valid, wr_tag, wr_target, wr_state,
        output rd_set,
        output pred_valid, pred_pc, pred_hit, pred_way, pred_taken, pred_target, pred_state,
        output lookup_cnt, hit_cnt
    );
endinterface

// File: rtl/btb_read.sv
// btb_read: lookup side of an 8-set, 2-way branch target buffer.
// A fetch PC sampled at edge N is compared against the synchronous BTB read data (plus any
// forwarded write) during the following cycle, and the registered prediction appears after
// edge N+1. Also keeps saturating lookup/hit counters.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - btb_read_if.slave: request/stall/flush, BTB read port (rd_set out, rd_* in),
//          write snoop (wr_*), prediction (pred_*) and statistics (lookup_cnt, hit_cnt)
module btb_read #(
    parameter int unsigned TAGW = 27
) (
    input logic    clk,
    input logic    rst,
    btb_read_if.slave bus
);
    localparam int unsigned PCW = TAGW + 3;

    // Stage 1 (request whose read data is arriving)
    logic            s1_valid_q;
    logic [PCW-1:0]  s1_pc_q;

    // Write seen in the cycle the file was read; the file returns pre-write data for it
    logic            fwd_hit_q;
    logic            fwd_way_q;
    logic            fwd_valid_q;
    logic [TAGW-1:0] fwd_tag_q;
    logic [31:0]     fwd_target_q;
    logic [1:0]      fwd_state_q;

    // Output register
    logic            pred_valid_q;
    logic [PCW-1:0]  pred_pc_q;
    logic            pred_hit_q;
    logic            pred_way_q;
    logic            pred_taken_q;
    logic [31:0]     pred_target_q;
    logic [1:0]      pred_state_q;
    logic [15:0]     lookup_cnt_q;
    logic [15:0]     hit_cnt_q;

    // Stage 1 merged way data and result
    logic            valid0, valid1;
    logic [TAGW-1:0] tag0, tag1;
    logic [31:0]     target0, target1;
    logic [1:0]      state0, state1;
    logic            hit0, hit1;
    logic            hit, way, taken;
    logic [1:0]      state;
    logic [31:0]     target;
    logic [PCW-1:0]  seq_pc;
    logic            load_valid;

    // While stalled, keep re-reading the held request's set so late writes are picked up.
    assign bus.rd_set = bus.stall ? s1_pc_q[2:0] : bus.req_pc[2:0];

    always_comb begin
        valid0  = bus.rd_valid0;
        tag0    = bus.rd_tag0;
        target0 = bus.rd_target0;
        state0  = bus.rd_state0;
        valid1  = bus.rd_valid1;
        tag1    = bus.rd_tag1;
        target1 = bus.rd_target1;
        state1  = bus.rd_state1;
        if (fwd_hit_q && !fwd_way_q) begin
            valid0  = fwd_valid_q;
            tag0    = fwd_tag_q;
            target0 = fwd_target_q;
            state0  = fwd_state_q;
        end
        if (fwd_hit_q && fwd_way_q) begin
            valid1  = fwd_valid_q;
            tag1    = fwd_tag_q;
            target1 = fwd_target_q;
            state1  = fwd_state_q;
        end
        hit0   = valid0 && (tag0 == s1_pc_q[PCW-1:3]);
        hit1   = valid1 && (tag1 == s1_pc_q[PCW-1:3]);
        hit    = hit0 || hit1;
        way    = !hit0 && hit1;
        state  = hit0 ? state0 : (hit1 ? state1 : 2'b00);
        taken  = hit && state[1];
        seq_pc = s1_pc_q + {{(PCW-1){1'b0}}, 1'b1};
        target = taken ? (hit0 ? target0 : target1) : 32'({seq_pc, 2'b00});
    end

    assign load_valid = !bus.stall && !bus.flush && s1_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_pc_q       <= '0;
            fwd_hit_q     <= 1'b0;
            fwd_way_q     <= 1'b0;
            fwd_valid_q   <= 1'b0;
            fwd_tag_q     <= '0;
            fwd_target_q  <= '0;
            fwd_state_q   <= '0;
            pred_valid_q  <= 1'b0;
            pred_pc_q     <= '0;
            pred_hit_q    <= 1'b0;
            pred_way_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pred_state_q  <= '0;
            lookup_cnt_q  <= '0;
            hit_cnt_q     <= '0;
        end else begin
            // Flush wins over stall for the valid bits only.
            if (bus.flush) begin
                s1_valid_q <= 1'b0;
            end else if (!bus.stall) begin
                s1_valid_q <= bus.req_valid;
            end
            if (!bus.stall) begin
                s1_pc_q <= bus.req_pc;
            end

            fwd_hit_q    <= bus.wr_en && (bus.wr_set == bus.rd_set);
            fwd_way_q    <= bus.wr_way;
            fwd_valid_q  <= bus.wr_valid;
            fwd_tag_q    <= bus.wr_tag;
            fwd_target_q <= bus.wr_target;
            fwd_state_q  <= bus.wr_state;

            if (bus.flush) begin
                pred_valid_q <= 1'b0;
            end else if (!bus.stall) begin
                pred_valid_q <= s1_valid_q;
            end
            if (!bus.stall) begin
                pred_pc_q     <= s1_pc_q;
                pred_hit_q    <= hit;
                pred_way_q    <= way;
                pred_taken_q  <= taken;
                pred_target_q <= target;
                pred_state_q  <= state;
            end

            if (load_valid) begin
                if (lookup_cnt_q != 16'hFFFF) begin
                    lookup_cnt_q <= lookup_cnt_q + 16'd1;
                end
                if (hit && (hit_cnt_q != 16'hFFFF)) begin
                    hit_cnt_q <= hit_cnt_q + 16'd1;
                end
            end
        end
    end

    assign bus.pred_valid  = pred_valid_q;
    assign bus.pred_pc     = pred_pc_q;
    assign bus.pred_hit    = pred_hit_q;
    assign bus.pred_way    = pred_way_q;
    assign bus.pred_taken  = pred_taken_q;
    assign bus.pred_target = pred_target_q;
    assign bus.pred_state  = pred_state_q;
    assign bus.lookup_cnt  = lookup_cnt_q;
    assign bus.hit_cnt     = hit_cnt_q;

endmodule
